// File: rtl/event_store_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : event_store_pkg
//  Description : Shared types and default constants for the event store.
//                FILL/FROZEN state encoding, the canonical record layout
//                {eta, phi, et, e} and the default geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package event_store_pkg;

    localparam int FIELD_W = 10;
    localparam int DEPTH   = 1024;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        FROZEN = 1'b1
    } state_t;

    // Canonical record layout at the default field width. Blocks built with
    // a non-default width declare a struct of identical field order locally.
    typedef struct packed {
        logic [FIELD_W-1:0] eta;
        logic [FIELD_W-1:0] phi;
        logic [FIELD_W-1:0] et;
        logic [FIELD_W-1:0] e;
    } record_t;

endpackage : event_store_pkg
`default_nettype wire

// File: rtl/event_store_ram.sv
`default_nettype none
// ============================================================================
//  Module      : store_ram
//  Description : Simple dual-port RAM, one write port and one synchronous
//                read port. No reset on the array so it maps to block RAM.
//  Ports       : clk              - clock
//                i_we/i_waddr/i_wdata - write port
//                i_re/i_raddr     - read enable / address
//                o_rdata          - read data, valid the cycle after i_re
//  Revision    : 1.0 - initial release
// ============================================================================
module store_ram #(
    parameter int WIDTH  = 40,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : store_ram
`default_nettype wire

// File: rtl/event_store.sv
`default_nettype none
// ============================================================================
//  Module      : event_store
//  Description : Collects threshold-filtered {eta,phi,et,e} records of one
//                event into RAM, freezes on evt_end, clears on evt_clr, and
//                serves random-access reads with a fixed 1-cycle latency.
//  Ports       : clk, rst_n (async active-low)
//                wr_valid/wr_ready, wr_eta/phi/et/e  - record write
//                et_min                               - et drop threshold
//                evt_end, evt_clr                     - freeze / clear pulses
//                rd_req, rd_addr                      - read request
//                rd_valid, rd_err, rd_eta/phi/et/e    - read response
//                count, frozen, overflow, drop_cnt    - status
//  Revision    : 1.0 - initial release
// ============================================================================
module event_store #(
    parameter int FIELD_W = event_store_pkg::FIELD_W,
    parameter int DEPTH   = event_store_pkg::DEPTH,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [FIELD_W-1:0] wr_eta,
    input  logic [FIELD_W-1:0] wr_phi,
    input  logic [FIELD_W-1:0] wr_et,
    input  logic [FIELD_W-1:0] wr_e,
    input  logic [FIELD_W-1:0] et_min,
    input  logic               evt_end,
    input  logic               evt_clr,
    input  logic               rd_req,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_valid,
    output logic               rd_err,
    output logic [FIELD_W-1:0] rd_eta,
    output logic [FIELD_W-1:0] rd_phi,
    output logic [FIELD_W-1:0] rd_et,
    output logic [FIELD_W-1:0] rd_e,
    output logic [ADDR_W:0]    count,
    output logic               frozen,
    output logic               overflow,
    output logic [15:0]        drop_cnt
);

    import event_store_pkg::*;

    typedef struct packed {
        logic [FIELD_W-1:0] eta;
        logic [FIELD_W-1:0] phi;
        logic [FIELD_W-1:0] et;
        logic [FIELD_W-1:0] e;
    } rec_t;

    localparam logic [ADDR_W:0] c_full_count = (ADDR_W+1)'(DEPTH);

    state_t          r_state;
    logic [ADDR_W:0] r_count;
    logic            r_overflow;
    logic [15:0]     r_drop_cnt;
    logic            r_rd_valid;
    logic            r_rd_err;
    rec_t            r_rd_hold;

    logic w_full;
    logic w_accept;
    logic w_keep;
    logic w_drop;
    rec_t w_wr_rec;
    rec_t w_ram_q;
    rec_t w_rd_rec;

    assign w_full   = (r_count == c_full_count);
    assign wr_ready = (r_state == FILL) && !w_full && !evt_clr;
    assign w_accept = wr_valid && wr_ready;
    assign w_keep   = w_accept && (wr_et >= et_min);
    assign w_drop   = w_accept && (wr_et < et_min);
    assign w_wr_rec = '{eta: wr_eta, phi: wr_phi, et: wr_et, e: wr_e};

    store_ram #(
        .WIDTH  (4*FIELD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_store_ram (
        .clk     (clk),
        .i_we    (w_keep),
        .i_waddr (r_count[ADDR_W-1:0]),
        .i_wdata (w_wr_rec),
        .i_re    (rd_req),
        .i_raddr (rd_addr),
        .o_rdata (w_ram_q)
    );

    // Control state; evt_clr has priority over everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (evt_clr) begin
            r_state    <= FILL;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (r_state == FILL && evt_end) begin
                r_state <= FROZEN;
            end
            if (w_keep) begin
                r_count <= r_count + 1'b1;
            end
            if (w_drop && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (r_state == FILL && w_full && wr_valid) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Read response qualifiers. The range check uses count as it stands in
    // the request cycle, so the slot being written that cycle reads as error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= rd_req;
            if (rd_req) begin
                r_rd_err <= ({1'b0, rd_addr} >= r_count);
            end
        end
    end

    // The RAM output register is unreset and may change on later reads, so
    // the last presented record is kept in a resettable hold register.
    always_comb begin
        w_rd_rec = r_rd_hold;
        if (r_rd_valid) begin
            w_rd_rec = r_rd_err ? '0 : w_ram_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_hold <= '0;
        end else if (r_rd_valid) begin
            r_rd_hold <= w_rd_rec;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_err   = r_rd_err;
    assign rd_eta   = w_rd_rec.eta;
    assign rd_phi   = w_rd_rec.phi;
    assign rd_et    = w_rd_rec.et;
    assign rd_e     = w_rd_rec.e;
    assign count    = r_count;
    assign frozen   = (r_state == FROZEN);
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule : event_store
`default_nettype wire

// File: tb/tb_event_store.sv
`default_nettype none
// ============================================================================
//  Module      : tb_event_store
//  Description : Directed self-checking bench for event_store (DEPTH=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_event_store;

    localparam int FIELD_W = 10;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               wr_valid;
    logic               wr_ready;
    logic [FIELD_W-1:0] wr_eta, wr_phi, wr_et, wr_e;
    logic [FIELD_W-1:0] et_min;
    logic               evt_end, evt_clr;
    logic               rd_req;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_valid, rd_err;
    logic [FIELD_W-1:0] rd_eta, rd_phi, rd_et, rd_e;
    logic [ADDR_W:0]    count;
    logic               frozen, overflow;
    logic [15:0]        drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    event_store #(
        .FIELD_W (FIELD_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_eta   (wr_eta),
        .wr_phi   (wr_phi),
        .wr_et    (wr_et),
        .wr_e     (wr_e),
        .et_min   (et_min),
        .evt_end  (evt_end),
        .evt_clr  (evt_clr),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_err   (rd_err),
        .rd_eta   (rd_eta),
        .rd_phi   (rd_phi),
        .rd_et    (rd_et),
        .rd_e     (rd_e),
        .count    (count),
        .frozen   (frozen),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int eta, input int phi, input int et, input int e);
        wr_valid = 1'b1;
        wr_eta   = FIELD_W'(eta);
        wr_phi   = FIELD_W'(phi);
        wr_et    = FIELD_W'(et);
        wr_e     = FIELD_W'(e);
    endtask

    task automatic read(input int addr);
        rd_req  = 1'b1;
        rd_addr = ADDR_W'(addr);
        step();
        rd_req  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 0; wr_eta = 0; wr_phi = 0; wr_et = 0; wr_e = 0;
        et_min = 0; evt_end = 0; evt_clr = 0; rd_req = 0; rd_addr = 0;
        step(); step();
        check("rst_count",    count,    0);
        check("rst_frozen",   frozen,   0);
        check("rst_overflow", overflow, 0);
        check("rst_drop",     drop_cnt, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_err",   rd_err,   0);
        check("rst_rd_et",    rd_et,    0);
        rst_n = 1'b1;
        step();
        check("idle_wr_ready", wr_ready, 1);

        // Threshold filtering: et 5 dropped, 20 and 30 stored.
        et_min = 10;
        put(1, 2, 5, 3);    step();
        put(11, 12, 20, 13); step();
        put(21, 22, 30, 23); step();
        wr_valid = 0;
        check("thr_count", count, 2);
        check("thr_drop",  drop_cnt, 1);
        read(0);
        check("thr_rd0_valid", rd_valid, 1);
        check("thr_rd0_err",   rd_err, 0);
        check("thr_rd0_et",    rd_et, 20);
        check("thr_rd0_eta",   rd_eta, 11);
        read(1);
        check("thr_rd1_et",    rd_et, 30);
        check("thr_rd1_phi",   rd_phi, 22);
        step();
        check("hold_valid",    rd_valid, 0);
        check("hold_e",        rd_e, 23);
        read(2);
        check("thr_rd2_err",   rd_err, 1);
        check("thr_rd2_et",    rd_et, 0);

        evt_clr = 1; step(); evt_clr = 0;
        check("clr_count", count, 0);
        check("clr_drop",  drop_cnt, 0);

        // evt_end coincident with the write at count=7.
        et_min = 0;
        for (int i = 0; i < 7; i++) begin
            put(i, i, 100 + i, i); step();
        end
        check("pre_end_count", count, 7);
        put(7, 7, 107, 7); evt_end = 1; step(); evt_end = 0;
        check("end_count",    count, 8);
        check("end_frozen",   frozen, 1);
        check("end_wr_ready", wr_ready, 0);
        put(9, 9, 109, 9); step(); wr_valid = 0;
        check("frz_count",    count, 8);
        check("frz_overflow", overflow, 0);
        evt_end = 1; step(); evt_end = 0;
        check("frz_end_again", frozen, 1);
        read(7);
        check("frz_rd7_et",  rd_et, 107);
        check("frz_rd7_err", rd_err, 0);
        read(8);
        check("frz_rd8_err", rd_err, 1);

        // Clear beats end while frozen; memory kept but invalid.
        evt_clr = 1; evt_end = 1; step(); evt_clr = 0; evt_end = 0;
        check("clr_end_frozen", frozen, 0);
        check("clr_end_count",  count, 0);
        read(0);
        check("clr_rd0_valid", rd_valid, 1);
        check("clr_rd0_err",   rd_err, 1);
        check("clr_rd0_eta",   rd_eta, 0);

        // Fill to capacity plus one; et equal to threshold is kept.
        et_min = 200;
        for (int i = 0; i < DEPTH + 1; i++) begin
            put(i, 50 + i, 200 + i, 300 + i); step();
        end
        wr_valid = 0;
        check("full_count",    count, DEPTH);
        check("full_wr_ready", wr_ready, 0);
        check("full_overflow", overflow, 1);
        check("full_drop",     drop_cnt, 0);
        read(DEPTH - 1);
        check("full_rd_et",  rd_et, 200 + DEPTH - 1);
        check("full_rd_e",   rd_e, 300 + DEPTH - 1);
        read(0);
        check("full_rd0_et", rd_et, 200);
        evt_clr = 1; step(); evt_clr = 0;
        check("clr_overflow", overflow, 0);

        // Reset arriving one cycle after a read request.
        et_min = 0;
        put(4, 5, 6, 7); step(); wr_valid = 0;
        rd_req = 1; rd_addr = 0;
        step();
        rd_req = 0;
        rst_n = 0;
        #1;
        check("rst_rd_valid_mid", rd_valid, 0);
        check("rst_count_mid",    count, 0);
        check("rst_rd_eta_mid",   rd_eta, 0);
        step();
        rst_n = 1;
        step();
        check("post_rst_valid", rd_valid, 0);
        step();
        check("post_rst_valid2", rd_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_event_store
`default_nettype wire
